// File: rtl/warp_fetch_pkg.sv
// rtl/warp_fetch_pkg.sv - shared constants and state encoding for the warp fetch unit
package warp_fetch_pkg;

    localparam int NUM_WARPS = 32;
    localparam int WARP_ID_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_REPORT,
        ST_WAIT_BU
    } fetch_state_t;

endpackage

// File: rtl/rr_pick32.sv
// rtl/rr_pick32.sv - rotate-priority encoder: first set mask bit at or above start, wrapping
module rr_pick32
    import warp_fetch_pkg::*;
(
    input  logic [NUM_WARPS-1:0] mask,
    input  logic [WARP_ID_W-1:0] start,
    output logic [WARP_ID_W-1:0] index,
    output logic                 any
);

    logic [WARP_ID_W-1:0] cand;

    // Scan from the farthest offset down so the nearest set bit is the last one written.
    always_comb begin
        index = '0;
        cand  = '0;
        any   = |mask;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            cand = start + WARP_ID_W'(i);
            if (mask[cand]) begin
                index = cand;
            end
        end
    end

endmodule

// File: rtl/warp_fetch.sv
// rtl/warp_fetch.sv - round-based warp instruction fetch: one outstanding imem request, IB push and BU report
module warp_fetch
    import warp_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_WARPS-1:0] warp_active,
    input  logic [NUM_WARPS-1:0] ib_free,
    input  logic [31:0]          next_pc [NUM_WARPS],
    input  logic [31:0]          pred    [NUM_WARPS],
    input  logic                 update_queue_valid,
    output logic                 m_tvalid_imem,
    input  logic                 m_tready_imem,
    output logic [31:0]          imem_addr,
    input  logic                 s_tvalid_imem,
    input  logic [31:0]          imem_rdata,
    output logic                 m_tvalid_ib,
    output logic [WARP_ID_W-1:0] ib_warp_id,
    output logic [31:0]          ib_instr,
    output logic [31:0]          ib_pc,
    output logic [31:0]          ib_pred,
    output logic                 m_tvalid_bu,
    output logic                 m_tlast_bu,
    output logic [WARP_ID_W-1:0] bu_warp_id
);

    fetch_state_t         state;
    fetch_state_t         state_nxt;
    logic [NUM_WARPS-1:0] round_mask;
    logic [NUM_WARPS-1:0] elig;
    logic [NUM_WARPS-1:0] mask_cleared;
    logic [NUM_WARPS-1:0] pick_mask;
    logic [WARP_ID_W-1:0] rr_ptr;
    logic [WARP_ID_W-1:0] cur_warp;
    logic [WARP_ID_W-1:0] pick_idx;
    logic                 pick_any;
    logic                 seen_low;
    logic                 last_warp;
    logic [31:0]          cur_pc;
    logic [31:0]          cur_pred;
    logic [31:0]          cur_instr;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            elig[i] = warp_active[i] & ib_free[i] & (|pred[i]);
        end
    end

    assign mask_cleared = round_mask & ~(NUM_WARPS'(1) << cur_warp);
    assign last_warp    = (mask_cleared == '0);
    // In IDLE the picker sees the fresh snapshot; mid-round it sees what is left.
    assign pick_mask    = (state == ST_IDLE) ? elig : mask_cleared;

    rr_pick32 u_pick (
        .mask  (pick_mask),
        .start (rr_ptr),
        .index (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        m_tvalid_imem = 1'b0;
        imem_addr     = '0;
        m_tvalid_ib   = 1'b0;
        ib_warp_id    = '0;
        ib_instr      = '0;
        ib_pc         = '0;
        ib_pred       = '0;
        m_tvalid_bu   = 1'b0;
        m_tlast_bu    = 1'b0;
        bu_warp_id    = '0;
        case (state)
            ST_IDLE: begin
                if (update_queue_valid && pick_any) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                m_tvalid_imem = 1'b1;
                imem_addr     = cur_pc;
                if (m_tready_imem) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (s_tvalid_imem) begin
                    state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                m_tvalid_ib = 1'b1;
                ib_warp_id  = cur_warp;
                ib_instr    = cur_instr;
                ib_pc       = cur_pc;
                ib_pred     = cur_pred;
                m_tvalid_bu = 1'b1;
                m_tlast_bu  = last_warp;
                bu_warp_id  = cur_warp;
                state_nxt   = last_warp ? ST_WAIT_BU : ST_REQ;
            end
            ST_WAIT_BU: begin
                if (seen_low && update_queue_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_mask <= '0;
            rr_ptr     <= '0;
            seen_low   <= 1'b0;
            cur_warp   <= '0;
            cur_pc     <= '0;
            cur_pred   <= '0;
            cur_instr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (update_queue_valid) begin
                        round_mask <= elig;
                        if (pick_any) begin
                            cur_warp <= pick_idx;
                            cur_pc   <= next_pc[pick_idx];
                            cur_pred <= pred[pick_idx];
                        end
                    end
                end
                ST_RESP: begin
                    if (s_tvalid_imem) begin
                        cur_instr <= imem_rdata;
                    end
                end
                ST_REPORT: begin
                    round_mask <= mask_cleared;
                    if (last_warp) begin
                        rr_ptr <= cur_warp + WARP_ID_W'(1);
                    end else begin
                        cur_warp <= pick_idx;
                        cur_pc   <= next_pc[pick_idx];
                        cur_pred <= pred[pick_idx];
                    end
                end
                ST_WAIT_BU: begin
                    // The queue must drop before rising again, so the closed round cannot re-arm.
                    if (!seen_low && !update_queue_valid) begin
                        seen_low <= 1'b1;
                    end else if (seen_low && update_queue_valid) begin
                        seen_low <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (m_tvalid_imem && !m_tready_imem) |=> (m_tvalid_imem && $stable(imem_addr)));
`endif

endmodule

// File: tb/tb_warp_fetch.sv
// tb/tb_warp_fetch.sv - directed self-checking bench for warp_fetch
module tb_warp_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] warp_active = '0;
    logic [31:0] ib_free = '0;
    logic [31:0] next_pc [32];
    logic [31:0] pred [32];
    logic        update_queue_valid = 1'b0;
    logic        m_tvalid_imem;
    logic        m_tready_imem;
    logic [31:0] imem_addr;
    logic        s_tvalid_imem;
    logic [31:0] imem_rdata;
    logic        m_tvalid_ib;
    logic [4:0]  ib_warp_id;
    logic [31:0] ib_instr;
    logic [31:0] ib_pc;
    logic [31:0] ib_pred;
    logic        m_tvalid_bu;
    logic        m_tlast_bu;
    logic [4:0]  bu_warp_id;

    warp_fetch dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .warp_active        (warp_active),
        .ib_free            (ib_free),
        .next_pc            (next_pc),
        .pred               (pred),
        .update_queue_valid (update_queue_valid),
        .m_tvalid_imem      (m_tvalid_imem),
        .m_tready_imem      (m_tready_imem),
        .imem_addr          (imem_addr),
        .s_tvalid_imem      (s_tvalid_imem),
        .imem_rdata         (imem_rdata),
        .m_tvalid_ib        (m_tvalid_ib),
        .ib_warp_id         (ib_warp_id),
        .ib_instr           (ib_instr),
        .ib_pc              (ib_pc),
        .ib_pred            (ib_pred),
        .m_tvalid_bu        (m_tvalid_bu),
        .m_tlast_bu         (m_tlast_bu),
        .bu_warp_id         (bu_warp_id)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_pc(input int i);
        return 32'h1000_0000 + (32'(i) << 4);
    endfunction

    function automatic logic [31:0] exp_pred(input int i);
        return 32'hFFFF_0000 | 32'(i);
    endfunction

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    int ib_ids[$];
    int bu_ids[$];
    int bu_lasts[$];
    int acc_cnt = 0, ib_cnt = 0, bu_cnt = 0, last_cnt = 0;
    int stall_cnt = 0, stall_cycles = 0, stall_bad = 0, idle_bad = 0, ovl_bad = 0;
    int resp_lat = 1, pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] stall_addr = '0;
    logic watch_idle = 1'b0;

    // Output monitor and instruction-memory model; inputs change at negedge only.
    initial begin
        m_tready_imem = 1'b1;
        s_tvalid_imem = 1'b0;
        imem_rdata    = '0;
        forever begin
            @(negedge clk);
            if (m_tvalid_ib) begin
                ib_cnt++;
                ib_ids.push_back(int'(ib_warp_id));
                check("ib_pc", ib_pc, exp_pc(int'(ib_warp_id)));
                check("ib_pred", ib_pred, exp_pred(int'(ib_warp_id)));
                check("ib_instr", ib_instr, exp_pc(int'(ib_warp_id)) ^ KEY);
                check("bu_with_ib", {m_tvalid_bu, bu_warp_id}, {1'b1, ib_warp_id});
            end
            if (m_tvalid_bu) begin
                bu_cnt++;
                bu_ids.push_back(int'(bu_warp_id));
                bu_lasts.push_back(int'(m_tlast_bu));
                if (m_tlast_bu) last_cnt++;
            end
            if (watch_idle && (m_tvalid_imem || m_tvalid_ib || m_tvalid_bu || m_tlast_bu ||
                imem_addr != 0 || ib_warp_id != 0 || ib_instr != 0 || ib_pc != 0 ||
                ib_pred != 0 || bu_warp_id != 0)) idle_bad++;
            s_tvalid_imem = 1'b0;
            imem_rdata    = '0;
            if (pend_cnt == 1) begin
                s_tvalid_imem = 1'b1;
                imem_rdata    = pend_addr ^ KEY;
                pend_cnt      = 0;
            end else if (pend_cnt > 1) begin
                pend_cnt--;
            end
            if (m_tvalid_imem && stall_cnt > 0) begin
                m_tready_imem = 1'b0;
                if (stall_cycles == 0) stall_addr = imem_addr;
                else if (imem_addr !== stall_addr) stall_bad++;
                stall_cycles++;
                stall_cnt--;
            end else begin
                m_tready_imem = 1'b1;
            end
            if (m_tvalid_imem && m_tready_imem) begin
                if (pend_cnt != 0) ovl_bad++;
                if (stall_cycles > 0 && imem_addr !== stall_addr) stall_bad++;
                acc_cnt++;
                pend_cnt  = resp_lat;
                pend_addr = imem_addr;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_last(input string tag);
        int start = last_cnt;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (last_cnt != start) break;
        end
        check({tag, "_done"}, 64'(last_cnt - start), 64'd1);
    endtask

    task automatic run_round(input string tag, input logic [31:0] m, input int n,
                             input int a, input int b);
        ib_ids.delete();
        bu_ids.delete();
        bu_lasts.delete();
        warp_active        = m;
        ib_free            = '1;
        update_queue_valid = 1'b1;
        wait_last(tag);
        update_queue_valid = 1'b0;
        cyc(2);
        check({tag, "_nib"}, 64'(ib_ids.size()), 64'(n));
        check({tag, "_nbu"}, 64'(bu_ids.size()), 64'(n));
        check({tag, "_ib0"}, 64'(q_at(ib_ids, 0)), 64'(a));
        check({tag, "_bu0"}, 64'(q_at(bu_ids, 0)), 64'(a));
        check({tag, "_last0"}, 64'(q_at(bu_lasts, 0)), 64'(n == 1));
        if (n == 2) begin
            check({tag, "_ib1"}, 64'(q_at(ib_ids, 1)), 64'(b));
            check({tag, "_bu1"}, 64'(q_at(bu_ids, 1)), 64'(b));
            check({tag, "_last1"}, 64'(q_at(bu_lasts, 1)), 64'd1);
        end
    endtask

    int a0, i0, b0;

    initial begin
        for (int i = 0; i < 32; i++) begin
            next_pc[i] = exp_pc(i);
            pred[i]    = exp_pred(i);
        end
        cyc(2);
        check("rst_imem_v", m_tvalid_imem, 0);
        check("rst_ib_v", m_tvalid_ib, 0);
        check("rst_bu_v", {m_tvalid_bu, m_tlast_bu}, 0);
        check("rst_payload", {imem_addr, ib_pc}, 0);
        check("rst_rr", dut.rr_ptr, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(2);
        check("idle_outs", {m_tvalid_imem, m_tvalid_ib, m_tvalid_bu, bu_warp_id}, 0);

        run_round("basic", (32'd1 << 2) | (32'd1 << 5), 2, 2, 5);
        check("basic_rr", dut.rr_ptr, 6);
        run_round("rr", (32'd1 << 2) | (32'd1 << 7), 2, 7, 2);
        check("rr_rr", dut.rr_ptr, 3);

        a0 = acc_cnt;
        stall_cycles = 0;
        stall_cnt    = 3;
        run_round("stall", 32'd1 << 9, 1, 9, 0);
        check("stall_cycles", 64'(stall_cycles), 3);
        check("stall_addr", stall_addr, exp_pc(9));
        check("stall_bad", 64'(stall_bad), 0);
        check("stall_acc", 64'(acc_cnt - a0), 1);

        run_round("pre_wrap", 32'd1 << 29, 1, 29, 0);
        check("pre_wrap_rr", dut.rr_ptr, 30);
        run_round("wrap", (32'd1 << 1) | (32'd1 << 31), 2, 31, 1);
        check("wrap_rr", dut.rr_ptr, 2);

        a0 = acc_cnt; i0 = ib_cnt; b0 = bu_cnt;
        watch_idle = 1'b1;
        warp_active = 32'd1 << 4;
        ib_free = '1;
        pred[4] = '0;
        update_queue_valid = 1'b1;
        cyc(10);
        pred[4] = exp_pred(4);
        ib_free[4] = 1'b0;
        cyc(10);
        update_queue_valid = 1'b0;
        cyc(2);
        watch_idle = 1'b0;
        ib_free = '1;
        check("filt_acc", 64'(acc_cnt - a0), 0);
        check("filt_ib", 64'(ib_cnt - i0), 0);
        check("filt_bu", 64'(bu_cnt - b0), 0);
        check("filt_idle", 64'(idle_bad), 0);

        ib_ids.delete();
        warp_active = 32'd1 << 3;
        update_queue_valid = 1'b1;
        wait_last("gate1");
        a0 = acc_cnt;
        cyc(5);
        check("gate_hold_acc", 64'(acc_cnt - a0), 0);
        update_queue_valid = 1'b0;
        cyc(2);
        update_queue_valid = 1'b1;
        wait_last("gate2");
        update_queue_valid = 1'b0;
        cyc(2);
        check("gate_acc", 64'(acc_cnt - a0), 1);
        check("gate_ids", {32'(q_at(ib_ids, 0)), 32'(q_at(ib_ids, 1))}, {32'd3, 32'd3});

        resp_lat = 4;
        a0 = acc_cnt;
        warp_active = 32'd1 << 6;
        update_queue_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (acc_cnt != a0) break;
        end
        check("rst_fetch_req", 64'(acc_cnt - a0), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        update_queue_valid = 1'b0;
        warp_active = '0;
        i0 = ib_cnt; b0 = bu_cnt;
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(10);
        check("rst_mid_ib", 64'(ib_cnt - i0), 0);
        check("rst_mid_bu", 64'(bu_cnt - b0), 0);
        check("rst_mid_rr", dut.rr_ptr, 0);
        check("rst_mid_imem", m_tvalid_imem, 0);
        check("one_outstanding", 64'(ovl_bad), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
